slot_bitmap_allocator: RTL and testbench

SLOT_BITMAP_ALLOCATOR -- requirements
Module: slot_bitmap_allocator

---
 rtl/slot_bitmap_allocator_if.sv | 43 ++++
 rtl/slot_bitmap_allocator.sv | 88 ++++++++
 tb/tb_slot_bitmap_allocator.sv | 132 +++++++++++++
 3 files changed

// File: rtl/slot_bitmap_allocator_if.sv
// slot_bitmap_allocator_if
//   Request/response bundle between a slot requester and the bitmap allocator.
//   master : requester side, drives flush/alloc_req/free_valid/free_index and
//            observes grant and status.
//   slave  : allocator side.
//   Signals:
//     flush        synchronous clear of all slots
//     alloc_req    requester wants one slot this cycle
//     alloc_ready  a free slot exists and no flush this cycle
//     alloc_index  granted slot, valid when alloc_req & alloc_ready
//     free_valid   release request this cycle
//     free_index   slot to release
//     busy_map     registered allocation bitmap
//     used_count   registered number of allocated slots
//     full, empty  decoded from used_count
//     double_free  sticky flag: a release hit an unallocated slot
interface slot_bitmap_allocator_if #(
    parameter int WIDTH = 4
);
    localparam int IW = $clog2(WIDTH);

    logic              flush;
    logic              alloc_req;
    logic              alloc_ready;
    logic [IW-1:0]     alloc_index;
    logic              free_valid;
    logic [IW-1:0]     free_index;
    logic [WIDTH-1:0]  busy_map;
    logic [IW:0]       used_count;
    logic              full;
    logic              empty;
    logic              double_free;

    modport master (
        output flush, alloc_req, free_valid, free_index,
        input  alloc_ready, alloc_index, busy_map, used_count, full, empty, double_free
    );

    modport slave (
        input  flush, alloc_req, free_valid, free_index,
        output alloc_ready, alloc_index, busy_map, used_count, full, empty, double_free
    );
endinterface

// File: rtl/slot_bitmap_allocator.sv
// slot_bitmap_allocator
//   Tracks WIDTH slots in a bitmap. Grants the lowest free slot combinationally
//   in the request cycle; releases and grants update the bitmap on the next
//   rising edge. Keeps a running count of allocated slots and a sticky
//   double-free error flag.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous, active-low reset
//     bus  slot_bitmap_allocator_if.slave (see interface header for signals)
//   WIDTH must be a power of two, >= 2, and match the interface instance.
module slot_bitmap_allocator #(
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    slot_bitmap_allocator_if.slave   bus
);
    localparam int IW = $clog2(WIDTH);
    localparam int CW = IW + 1;

    logic [WIDTH-1:0] busy_map_q, busy_map_d;
    logic [CW-1:0]    used_count_q, used_count_d;
    logic             double_free_q, double_free_d;

    logic             full;
    logic             empty;
    logic             alloc_ready;
    logic [IW-1:0]    alloc_index;
    logic             fire;
    logic             eff_free;
    logic             bad_free;

    // Lowest clear bit of the registered map. Scanning downward lets the
    // lowest index win; the result stays 0 when every slot is busy.
    always_comb begin
        alloc_index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!busy_map_q[i]) alloc_index = IW'(i);
        end
    end

    assign full        = (used_count_q == CW'(WIDTH));
    assign empty       = (used_count_q == '0);
    assign alloc_ready = !full && !bus.flush;
    assign fire        = bus.alloc_req && alloc_ready;

    // A release only counts against a busy slot; flush swallows releases
    // entirely, including the error check.
    assign eff_free = bus.free_valid && busy_map_q[bus.free_index] && !bus.flush;
    assign bad_free = bus.free_valid && !busy_map_q[bus.free_index] && !bus.flush;

    always_comb begin
        busy_map_d    = busy_map_q;
        used_count_d  = used_count_q;
        double_free_d = double_free_q || bad_free;
        if (bus.flush) begin
            busy_map_d   = '0;
            used_count_d = '0;
        end else begin
            // Grant targets a free slot and release targets a busy one, so
            // both updates touch different bits.
            if (fire)     busy_map_d[alloc_index]    = 1'b1;
            if (eff_free) busy_map_d[bus.free_index] = 1'b0;
            if (fire && !eff_free)      used_count_d = used_count_q + CW'(1);
            else if (!fire && eff_free) used_count_d = used_count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_map_q    <= '0;
            used_count_q  <= '0;
            double_free_q <= 1'b0;
        end else begin
            busy_map_q    <= busy_map_d;
            used_count_q  <= used_count_d;
            double_free_q <= double_free_d;
        end
    end

    assign bus.alloc_ready = alloc_ready;
    assign bus.alloc_index = alloc_index;
    assign bus.busy_map    = busy_map_q;
    assign bus.used_count  = used_count_q;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.double_free = double_free_q;
endmodule

// File: tb/tb_slot_bitmap_allocator.sv
// tb_slot_bitmap_allocator
//   Directed vectors for WIDTH = 4. Each vector drives inputs just after a
//   rising edge and queues the outputs expected during that same cycle; a
//   monitor samples on the falling edge and compares against the queue head.
module tb_slot_bitmap_allocator;
    localparam int WIDTH = 4;

    typedef struct {
        logic       rdy;
        logic [1:0] idx;
        logic [3:0] map;
        logic [2:0] cnt;
        logic       full;
        logic       empty;
        logic       df;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    slot_bitmap_allocator_if #(.WIDTH(WIDTH)) bus ();

    slot_bitmap_allocator #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents mid-cycle with the oldest
    // queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("alloc_ready", int'(bus.alloc_ready), int'(e.rdy));
            check("alloc_index", int'(bus.alloc_index), int'(e.idx));
            check("busy_map",    int'(bus.busy_map),    int'(e.map));
            check("used_count",  int'(bus.used_count),  int'(e.cnt));
            check("full",        int'(bus.full),        int'(e.full));
            check("empty",       int'(bus.empty),       int'(e.empty));
            check("double_free", int'(bus.double_free), int'(e.df));
        end
    end

    // Drive one cycle of inputs and queue the outputs expected in that cycle.
    task automatic vec(input logic r, input logic fl, input logic req,
                       input logic fv, input logic [1:0] fi,
                       input logic rdy, input logic [1:0] idx, input logic [3:0] map,
                       input logic [2:0] cnt, input logic full, input logic empty,
                       input logic df);
        exp_t e;
        @(posedge clk);
        #1;
        rst            = r;
        bus.flush      = fl;
        bus.alloc_req  = req;
        bus.free_valid = fv;
        bus.free_index = fi;
        e.rdy = rdy; e.idx = idx; e.map = map; e.cnt = cnt;
        e.full = full; e.empty = empty; e.df = df;
        sb.push_back(e);
    endtask

    initial begin
        bus.flush      = 1'b0;
        bus.alloc_req  = 1'b0;
        bus.free_valid = 1'b0;
        bus.free_index = 2'd0;

        //   rst fl req fv fi    rdy idx map      cnt full empty df
        // Held in reset
        vec(0, 0, 0, 0, 2'd0,  1, 2'd0, 4'b0000, 3'd0, 0, 1, 0);
        // Release reset, then request four cycles in a row
        vec(1, 0, 1, 0, 2'd0,  1, 2'd0, 4'b0000, 3'd0, 0, 1, 0);
        vec(1, 0, 1, 0, 2'd0,  1, 2'd1, 4'b0001, 3'd1, 0, 0, 0);
        vec(1, 0, 1, 0, 2'd0,  1, 2'd2, 4'b0011, 3'd2, 0, 0, 0);
        vec(1, 0, 1, 0, 2'd0,  1, 2'd3, 4'b0111, 3'd3, 0, 0, 0);
        // Full: free 2 with a request in the same cycle, no grant
        vec(1, 0, 1, 1, 2'd2,  0, 2'd0, 4'b1111, 3'd4, 1, 0, 0);
        // Slot 2 eligible again; free 3 to reach 0011
        vec(1, 0, 0, 1, 2'd3,  1, 2'd2, 4'b1011, 3'd3, 0, 0, 0);
        // From 0011: grant 2 while freeing 0
        vec(1, 0, 1, 1, 2'd0,  1, 2'd2, 4'b0011, 3'd2, 0, 0, 0);
        // 0110: free 1
        vec(1, 0, 0, 1, 2'd1,  1, 2'd0, 4'b0110, 3'd2, 0, 0, 0);
        // 0100: grant 0 while freeing 2
        vec(1, 0, 1, 1, 2'd2,  1, 2'd0, 4'b0100, 3'd1, 0, 0, 0);
        // 0001: free unallocated slot 3
        vec(1, 0, 0, 1, 2'd3,  1, 2'd1, 4'b0001, 3'd1, 0, 0, 0);
        // Map unchanged, error flag set; grant 1 then 2
        vec(1, 0, 1, 0, 2'd0,  1, 2'd1, 4'b0001, 3'd1, 0, 0, 1);
        vec(1, 0, 1, 0, 2'd0,  1, 2'd2, 4'b0011, 3'd2, 0, 0, 1);
        // 0111: flush overrides request and free
        vec(1, 1, 1, 1, 2'd1,  0, 2'd3, 4'b0111, 3'd3, 0, 0, 1);
        // Cleared; error flag survives flush; build state back up
        vec(1, 0, 1, 0, 2'd0,  1, 2'd0, 4'b0000, 3'd0, 0, 1, 1);
        vec(1, 0, 1, 0, 2'd0,  1, 2'd1, 4'b0001, 3'd1, 0, 0, 1);
        vec(1, 0, 0, 0, 2'd0,  1, 2'd2, 4'b0011, 3'd2, 0, 0, 1);
        // Asynchronous reset mid-cycle from 0011
        vec(0, 0, 0, 0, 2'd0,  1, 2'd0, 4'b0000, 3'd0, 0, 1, 0);
        // First edge after release processes the request
        vec(1, 0, 1, 0, 2'd0,  1, 2'd0, 4'b0000, 3'd0, 0, 1, 0);
        vec(1, 0, 0, 0, 2'd0,  1, 2'd1, 4'b0001, 3'd1, 0, 0, 0);

        begin
            int budget = 100;
            while (sb.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (sb.size() > 0) begin
                errors++;
                $display("FAIL drain: %0d expectations left, expected 0", sb.size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
